sum_sq_fifo_writer: RTL

- Consumes the 26-bit sum-of-squares word that the NIOS PIO drives and turns each new software write into one entry of a small FIFO.
- Presents the FIFO contents as a valid/ready stream to the correlation/threshold logic downstream.
- Sits directly downstream of the sum-of-squares PIO output port in the ultrasonic receive path.

---
 rtl/sum_sq_pkg.sv | 10 +
 rtl/sum_sq_fifo_mem.sv | 27 ++
 rtl/sum_sq_fifo_writer.sv | 107 ++++++++++
 3 files changed

// File: rtl/sum_sq_pkg.sv
// Shared widths and payload type for the sum-of-squares PIO-to-FIFO path.
package sum_sq_pkg;

  localparam int unsigned SUM_SQ_W   = 26;
  localparam int unsigned PAYLOAD_W  = 25;
  localparam int unsigned TOGGLE_BIT = 25;

  typedef logic [PAYLOAD_W-1:0] sum_sq_word_t;

endpackage

// File: rtl/sum_sq_fifo_mem.sv
// DEPTH x PAYLOAD_W storage: one synchronous write port, one asynchronous read port.
module sum_sq_fifo_mem
  import sum_sq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  sum_sq_word_t wdata,
  input  logic [AW-1:0] raddr,
  output sum_sq_word_t rdata
);

  sum_sq_word_t mem [DEPTH];

  // No reset: readers only look at slots that have been written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sum_sq_fifo_writer.sv
// Turns each toggle of pio_data[25] into one FIFO entry, drained as a valid/ready stream.
// Optional statistics outputs (drop_count, max_level) are built when SUM_SQ_FIFO_STATS_EN is defined.
module sum_sq_fifo_writer
  import sum_sq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SUM_SQ_W-1:0]  pio_data,
  input  logic                 clear,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW:0]          level,
  output logic                 overflow
`ifdef SUM_SQ_FIFO_STATS_EN
  ,
  output logic [15:0]          drop_count,
  output logic [AW:0]          max_level
`endif
);

  logic         tog_q;
  logic [AW:0]  wr_ptr, wr_ptr_d;
  logic [AW:0]  rd_ptr, rd_ptr_d;
  logic         push, pop, full, empty, wr_en, drop;
  sum_sq_word_t rdata;

  assign push  = pio_data[TOGGLE_BIT] ^ tog_q;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & out_ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign wr_en = push & (~full | pop) & ~clear;
  assign drop  = push & full & ~pop & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      tog_q  <= pio_data[TOGGLE_BIT];
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      if (clear) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  sum_sq_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (pio_data[PAYLOAD_W-1:0]),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign out_valid = ~empty;
  assign out_data  = out_valid ? rdata : '0;
  assign level     = wr_ptr - rd_ptr;

`ifdef SUM_SQ_FIFO_STATS_EN
  logic [AW:0] level_d;
  assign level_d = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      max_level  <= '0;
    end else if (clear) begin
      drop_count <= '0;
      max_level  <= '0;
    end else begin
      if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
      if (level_d > max_level) begin
        max_level <= level_d;
      end
    end
  end
`endif

endmodule
